// File: rtl/sd_stream_scheduler.sv
// sd_stream_scheduler: buffers recorded bytes into SD-sized blocks, writes them
// to consecutive sectors, prefetches recorded sectors into a playback FIFO and
// arbitrates the single SD block controller between the two paths.
// Ports: clk/rst (async, active-high); record_req/rec_valid/rec_byte record in;
// play_req/play_pop/play_byte playback; sd_* SD controller handshake;
// rec_overflow/play_underrun sticky flags; rec_blocks sectors in take; busy.
// Optional: define LOOP_PLAYBACK_EN to wrap the read pointer at end of track.
module sd_stream_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter int unsigned BLOCK_BYTES = 512,
  parameter int unsigned BASE_BLOCK  = 0,
  parameter int unsigned MAX_BLOCKS  = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        record_req,
  input  logic        play_req,
  input  logic        rec_valid,
  input  logic [7:0]  rec_byte,
  input  logic        play_pop,
  output logic [7:0]  play_byte,
  input  logic        sd_ready,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic        sd_ready_for_next_byte,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic        rec_overflow,
  output logic        play_underrun,
  output logic [16:0] rec_blocks,
  output logic        busy
);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam int unsigned XW    = $clog2(BLOCK_BYTES);
  localparam int unsigned BW    = 17;
  localparam int unsigned SHIFT = $clog2(BLOCK_BYTES);
  localparam int unsigned TW    = $clog2(MAX_BLOCKS) + SHIFT + 1;
  localparam logic [TW-1:0] REC_LIMIT = TW'(MAX_BLOCKS) << SHIFT;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_WAIT, S_RD_CMD, S_RD_DATA, S_RD_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      rec_mem  [FIFO_DEPTH];
  logic [7:0]      play_mem [FIFO_DEPTH];
  logic [AW-1:0]   rec_wr_idx_q, rec_wr_idx_d, rec_rd_idx_q, rec_rd_idx_d;
  logic [AW-1:0]   play_wr_idx_q, play_wr_idx_d, play_rd_idx_q, play_rd_idx_d;
  logic [CW-1:0]   rec_cnt_q, rec_cnt_d, play_cnt_q, play_cnt_d;
  logic [XW-1:0]   xfer_q, xfer_d;
  logic [BW-1:0]   rec_blocks_q, rec_blocks_d, rd_blk_q, rd_blk_d;
  logic [TW-1:0]   rec_total_q, rec_total_d;
  logic            pad_pending_q, pad_pending_d;
  logic            rec_req_q, play_req_q;
  logic            rec_overflow_q, rec_overflow_d, play_underrun_q, play_underrun_d;
  logic            sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d, busy_q, busy_d;
  logic [31:0]     sd_addr_q, sd_addr_d;
  logic [7:0]      sd_din_q, sd_din_d, play_byte_q, play_byte_d;

  // Mode edges, and the post-flush view of each FIFO for this cycle.
  logic            rec_start, rec_stop, play_start, play_active, track_done;
  logic            rec_push, rec_pop, rec_drop, play_push, play_pop_ok, underrun_set;
  logic            wr_elig, rd_elig;
  logic [CW-1:0]   rec_cnt_base, play_cnt_base;
  logic [AW-1:0]   rec_wr_base, rec_rd_base, play_wr_base, play_rd_base;
  logic [BW-1:0]   rec_blocks_base, rd_blk_base;
  logic [TW-1:0]   rec_total_base;
  logic [7:0]      rec_head, play_head;

  // FIFO bookkeeping: flush on mode start, then count + push - pop.
  always_comb begin
    rec_start       = record_req && !rec_req_q;
    rec_stop        = !record_req && rec_req_q;
    play_start      = play_req && !play_req_q;
    play_active     = play_req && !record_req;
    rec_cnt_base    = rec_start ? '0 : rec_cnt_q;
    rec_wr_base     = rec_start ? '0 : rec_wr_idx_q;
    rec_rd_base     = rec_start ? '0 : rec_rd_idx_q;
    rec_total_base  = rec_start ? '0 : rec_total_q;
    rec_blocks_base = rec_start ? '0 : rec_blocks_q;
    play_cnt_base   = play_start ? '0 : play_cnt_q;
    play_wr_base    = play_start ? '0 : play_wr_idx_q;
    play_rd_base    = play_start ? '0 : play_rd_idx_q;
    rd_blk_base     = play_start ? '0 : rd_blk_q;
`ifdef LOOP_PLAYBACK_EN
    track_done      = 1'b0;
`else
    track_done      = rd_blk_base >= rec_blocks_q;
`endif
    rec_drop  = record_req && rec_valid &&
                (rec_cnt_base == CW'(FIFO_DEPTH) || rec_total_base >= REC_LIMIT);
    rec_push  = record_req && rec_valid && !rec_drop;
    rec_pop   = (state_q == S_WR_DATA) && sd_ready_for_next_byte && (rec_cnt_base != '0);
    play_push = (state_q == S_RD_DATA) && sd_byte_available;
    play_pop_ok  = play_active && play_pop && (play_cnt_base != '0);
    underrun_set = play_active && play_pop && (play_cnt_base == '0) && !track_done;

    rec_cnt_d     = rec_cnt_base + CW'(rec_push) - CW'(rec_pop);
    rec_wr_idx_d  = rec_wr_base + AW'(rec_push);
    rec_rd_idx_d  = rec_rd_base + AW'(rec_pop);
    rec_total_d   = rec_total_base + TW'(rec_push);
    play_cnt_d    = play_cnt_base + CW'(play_push) - CW'(play_pop_ok);
    play_wr_idx_d = play_wr_base + AW'(play_push);
    play_rd_idx_d = play_rd_base + AW'(play_pop_ok);

    // A byte pushed into an otherwise empty FIFO is not readable from memory yet.
    rec_head  = (rec_push && rec_cnt_d == CW'(1)) ? rec_byte : rec_mem[rec_rd_idx_d];
    play_head = (play_push && play_cnt_d == CW'(1)) ? sd_dout : play_mem[play_rd_idx_d];

    pad_pending_d   = rec_start ? 1'b0 : (rec_stop ? 1'b1 : pad_pending_q);
    rec_overflow_d  = (rec_start ? 1'b0 : rec_overflow_q) | rec_drop;
    play_underrun_d = (play_start ? 1'b0 : play_underrun_q) | underrun_set;

    wr_elig = (rec_cnt_base >= CW'(BLOCK_BYTES)) || (pad_pending_q && rec_cnt_base != '0);
    rd_elig = play_active && (rec_blocks_q != '0) && !track_done &&
              (play_cnt_base <= CW'(FIFO_DEPTH - BLOCK_BYTES));
  end

  // Transfer FSM; write is checked first so recording never waits on playback.
  always_comb begin
    state_d      = state_q;
    xfer_d       = xfer_q;
    sd_addr_d    = sd_addr_q;
    rec_blocks_d = rec_blocks_base;
    rd_blk_d     = rd_blk_base;
    unique case (state_q)
      S_IDLE: begin
        if (sd_ready && wr_elig) begin
          state_d   = S_WR_CMD;
          sd_addr_d = (32'(BASE_BLOCK) + 32'(rec_blocks_base)) * 32'(BLOCK_BYTES);
        end else if (sd_ready && rd_elig) begin
          state_d   = S_RD_CMD;
          sd_addr_d = (32'(BASE_BLOCK) + 32'(rd_blk_base)) * 32'(BLOCK_BYTES);
        end
      end
      S_WR_CMD: if (!sd_ready) begin state_d = S_WR_DATA; xfer_d = '0; end
      S_WR_DATA: begin
        if (sd_ready_for_next_byte) begin
          xfer_d = xfer_q + XW'(1);
          if (xfer_q == XW'(BLOCK_BYTES - 1)) state_d = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        if (sd_ready) begin
          state_d      = S_IDLE;
          rec_blocks_d = rec_blocks_base + BW'(1);
        end
      end
      S_RD_CMD: if (!sd_ready) begin state_d = S_RD_DATA; xfer_d = '0; end
      S_RD_DATA: begin
        if (sd_byte_available) begin
          xfer_d = xfer_q + XW'(1);
          if (xfer_q == XW'(BLOCK_BYTES - 1)) state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (sd_ready) begin
          state_d = S_IDLE;
`ifdef LOOP_PLAYBACK_EN
          rd_blk_d = (rd_blk_base + BW'(1) >= rec_blocks_q) ? '0 : rd_blk_base + BW'(1);
`else
          rd_blk_d = rd_blk_base + BW'(1);
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    sd_wr_d     = (state_d == S_WR_CMD);
    sd_rd_d     = (state_d == S_RD_CMD);
    busy_d      = (state_d != S_IDLE);
    // Once the real bytes of a padded block run out, zeros go to the card.
    sd_din_d    = ((state_d == S_WR_CMD || state_d == S_WR_DATA) && rec_cnt_d != '0) ?
                  rec_head : 8'h00;
    play_byte_d = (play_active && play_cnt_d != '0) ? play_head : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rec_push)  rec_mem[rec_wr_base]   <= rec_byte;
    if (play_push) play_mem[play_wr_base] <= sd_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;       xfer_q <= '0;
      rec_wr_idx_q <= '0;      rec_rd_idx_q <= '0;    rec_cnt_q <= '0;
      play_wr_idx_q <= '0;     play_rd_idx_q <= '0;   play_cnt_q <= '0;
      rec_blocks_q <= '0;      rd_blk_q <= '0;        rec_total_q <= '0;
      pad_pending_q <= 1'b0;   rec_req_q <= 1'b0;     play_req_q <= 1'b0;
      rec_overflow_q <= 1'b0;  play_underrun_q <= 1'b0;
      sd_rd_q <= 1'b0;         sd_wr_q <= 1'b0;       busy_q <= 1'b0;
      sd_addr_q <= '0;         sd_din_q <= '0;        play_byte_q <= '0;
    end else begin
      state_q <= state_d;       xfer_q <= xfer_d;
      rec_wr_idx_q <= rec_wr_idx_d;   rec_rd_idx_q <= rec_rd_idx_d;   rec_cnt_q <= rec_cnt_d;
      play_wr_idx_q <= play_wr_idx_d; play_rd_idx_q <= play_rd_idx_d; play_cnt_q <= play_cnt_d;
      rec_blocks_q <= rec_blocks_d;   rd_blk_q <= rd_blk_d;           rec_total_q <= rec_total_d;
      pad_pending_q <= pad_pending_d; rec_req_q <= record_req;        play_req_q <= play_req;
      rec_overflow_q <= rec_overflow_d; play_underrun_q <= play_underrun_d;
      sd_rd_q <= sd_rd_d;       sd_wr_q <= sd_wr_d;    busy_q <= busy_d;
      sd_addr_q <= sd_addr_d;   sd_din_q <= sd_din_d;  play_byte_q <= play_byte_d;
    end
  end

  assign play_byte     = play_byte_q;
  assign sd_rd         = sd_rd_q;
  assign sd_wr         = sd_wr_q;
  assign sd_addr       = sd_addr_q;
  assign sd_din        = sd_din_q;
  assign rec_overflow  = rec_overflow_q;
  assign play_underrun = play_underrun_q;
  assign rec_blocks    = rec_blocks_q;
  assign busy          = busy_q;
endmodule

// File: doc/sd_stream_scheduler.md
Name: sd_stream_scheduler

Overview:
- Sits between the recorder's sample path and the SPI SD-card block controller; all logic on the 100 MHz system clock.
- Buffers recorded bytes into 512-byte blocks and schedules block writes to consecutive SD sectors.
- Prefetches recorded sectors into a playback FIFO for the transmit path.
- Arbitrates the single SD controller between record and playback traffic.

Parameters:
- FIFO_DEPTH, 1024, bytes per record FIFO and per play FIFO; power of two, ≥1024.
- BLOCK_BYTES, 512, bytes per SD transfer.
- BASE_BLOCK, 0, first SD sector used for the track.
- MAX_BLOCKS, 65536, sector capacity of the track region.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous reset, active-high
- record_req  in  1  level; high = recording
- play_req  in  1  level; high = playback (ignored while record_req high)
- rec_valid  in  1  one-cycle strobe, new recorded byte
- rec_byte  in  8  recorded sample byte
- play_pop  in  1  one-cycle strobe, consumer takes play_byte
- play_byte  out  8  current playback byte
- sd_ready  in  1  SD controller idle/ready
- sd_rd  out  1  read command
- sd_wr  out  1  write command
- sd_addr  out  32  byte address = (BASE_BLOCK + block index) × 512
- sd_din  out  8  write byte to controller
- sd_ready_for_next_byte  in  1  strobe, controller consumed sd_din
- sd_dout  in  8  read byte from controller
- sd_byte_available  in  1  strobe, sd_dout valid
- rec_overflow  out  1  sticky, record FIFO dropped a byte
- play_underrun  out  1  sticky, pop on empty play FIFO
- rec_blocks  out  17  sectors recorded in last/current take
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FIFOs empty; FSM IDLE; rec_blocks 0.
- Record start (rising edge of record_req):
  - write block pointer ← 0; rec_blocks ← 0; record FIFO flushed; rec_overflow cleared.
- Record stop (falling edge of record_req):
  - Remaining partial block is zero-padded to 512 and written, counted in rec_blocks.
  - Padding is written only if at least one byte of the block is pending.
- Record FIFO full with rec_valid high: byte dropped; rec_overflow ← 1.
- Write pointer reaching MAX_BLOCKS: further bytes dropped; rec_overflow ← 1.
- Play start (rising edge of play_req):
  - read block pointer ← 0; play FIFO flushed; play_underrun cleared.
- Write eligible: record FIFO holds ≥ BLOCK_BYTES bytes, or a pad flush is pending.
- Read eligible: play_req && !record_req && rec_blocks ≠ 0 && play FIFO free space ≥ BLOCK_BYTES && end not reached.
- Arbitration in IDLE with sd_ready high:
  - If both requests are eligible, write wins. The record path must never drop bytes because of playback traffic.
- FSM states:
  - IDLE → WR_CMD or RD_CMD.
  - WR_CMD: sd_wr = 1 and sd_addr stable; leave on sd_ready low → WR_DATA.
  - WR_DATA: sd_din = FIFO head (or 0 while padding). Each sd_ready_for_next_byte pops one byte. After the 512th byte → WR_WAIT.
  - WR_WAIT: on sd_ready high, write pointer += 1, rec_blocks updated → IDLE.
  - RD_CMD: sd_rd = 1; leave on sd_ready low → RD_DATA.
  - RD_DATA: each sd_byte_available pushes sd_dout into the play FIFO. After the 512th byte → RD_WAIT.
  - RD_WAIT: on sd_ready high, read pointer += 1 → IDLE.
- sd_addr and sd_rd/sd_wr are registered and held constant for the whole command phase.
- Transfer already in flight when the mode request drops: completes normally (512 bytes); no aborted transfers.
- play_byte: registered head of the play FIFO. Reads 0 when empty or when not playing.
- Pop on empty play FIFO: play_underrun ← 1; output stays 0.
- Pop, push and byte-strobe on the same cycle are all handled; FIFO occupancy is updated as count + push − pop.
- Reset asserted mid-transfer: immediate return to IDLE, commands deasserted. The SD controller is reset by the same rst.

Optional Feature:
- Macro: LOOP_PLAYBACK_EN.
- Defined: when the read pointer reaches rec_blocks it wraps to 0 and prefetch continues for as long as play_req is high.
- Not defined: prefetch stops at rec_blocks. Once the FIFO drains, play_byte is 0; no underrun is flagged after end of track.

Test Plan:
- Record 1024 bytes 0x00..0xFF repeating, then drop record_req → exactly two sd_wr commands at addresses 0x0 and 0x200, bytes in order; rec_blocks = 2; no padding block.
- Record 600 bytes, stop → second block contains bytes 512..599 then 424 zero bytes; rec_blocks = 2.
- With 2 recorded blocks, raise play_req and pop 1024 times → sd_rd at 0x0 and 0x200; popped data equals the recorded data; play_underrun = 0.
- Feed rec_valid every cycle with sd_ready held low → FIFO fills after 1024 bytes; 1025th byte dropped; rec_overflow = 1.
- Record 512 bytes while a playback read is in flight; both eligible in IDLE → read completes first, then the write is granted.
- LOOP_PLAYBACK_EN defined, 1 block recorded, pop 1536 bytes → three sd_rd commands, all at address 0x0. Undefined → one read; bytes 513+ read 0.
